// File: rtl/fx_sched_pkg.sv
// Shared slot map, RAM request bundle and slot classification for the
// effects-path sample scheduler.
package fx_sched_pkg;

    localparam int RAM_ADDR_W = 13;
    localparam int RAM_DATA_W = 11;

    localparam logic [9:0] SLOT_LOAD    = 10'd0;
    localparam logic [9:0] SLOT_LAST_FX = 10'd4;
    localparam logic [9:0] SLOT_WRITE   = 10'd5;
    localparam logic [9:0] SLOT_DAC     = 10'd6;
    localparam logic [9:0] SLOT_HOST    = 10'd7;
    localparam logic [9:0] COUNTER_IDLE = 10'h3FF;

    typedef enum logic [1:0] {
        PH_FX,
        PH_WRITE,
        PH_DAC,
        PH_HOST
    } slot_phase_e;

    typedef struct packed {
        logic [RAM_ADDR_W-1:0] addr;
        logic [RAM_DATA_W-1:0] wdata;
        logic                  we;
    } ram_req_t;

    // Offset form keeps the lower bound meaningful without an always-true compare.
    function automatic slot_phase_e slot_phase(input logic [9:0] c);
        slot_phase_e ph;
        if ((c - SLOT_LOAD) <= (SLOT_LAST_FX - SLOT_LOAD)) ph = PH_FX;
        else if (c == SLOT_WRITE)                         ph = PH_WRITE;
        else if (c == SLOT_DAC)                           ph = PH_DAC;
        else if (c >= SLOT_HOST)                          ph = PH_HOST;
        else                                              ph = PH_DAC;
        return ph;
    endfunction

endpackage

// File: rtl/ram_port_mux.sv
// Slot-based owner select for the single delay-RAM port: effects in the
// fixed slots, host in the idle window unless a sample is being accepted.
module ram_port_mux
    import fx_sched_pkg::*;
(
    input  logic                  active,
    input  logic [9:0]            counter,
    input  logic                  adc_ready,
    input  logic [RAM_ADDR_W-1:0] fx_address,
    input  logic [RAM_DATA_W-1:0] fx_write_voltage,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [RAM_ADDR_W-1:0] host_addr,
    input  logic [RAM_DATA_W-1:0] host_wdata,
    output ram_req_t              ram_req,
    output logic                  host_gnt
);

    always_comb begin
        ram_req  = '0;
        host_gnt = 1'b0;
        if (active) begin
            unique case (slot_phase(counter))
                PH_FX: begin
                    ram_req.addr = fx_address;
                end
                PH_WRITE: begin
                    ram_req.addr  = fx_address;
                    ram_req.wdata = fx_write_voltage;
                    ram_req.we    = 1'b1;
                end
                PH_DAC: begin
                    ram_req = '0;
                end
                PH_HOST: begin
                    if (host_req && !adc_ready) begin
                        host_gnt      = 1'b1;
                        ram_req.addr  = host_addr;
                        ram_req.wdata = host_wdata;
                        ram_req.we    = host_we;
                    end
                end
                default: ram_req = '0;
            endcase
        end
    end

endmodule

// File: rtl/fx_scheduler.sv
// Per-sample slot scheduler: frame counter, sample latch, DAC register,
// overrun flag and host read return around the delay-RAM port mux.
module fx_scheduler
    import fx_sched_pkg::*;
#(
    parameter int SAMPLE_W = 10,
    parameter int ADDR_W   = RAM_ADDR_W,
    parameter int DATA_W   = RAM_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                adc_ready,
    input  logic [SAMPLE_W-1:0] adc_data,
    output logic [SAMPLE_W-1:0] sample_voltage,
    output logic [9:0]          counter,
    input  logic [ADDR_W-1:0]   fx_address,
    input  logic [DATA_W-1:0]   fx_write_voltage,
    input  logic [DATA_W-1:0]   fx_send_voltage,
    output logic [DATA_W-1:0]   fx_read_voltage,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_rdata,
    input  logic                host_req,
    input  logic                host_we,
    input  logic [ADDR_W-1:0]   host_addr,
    input  logic [DATA_W-1:0]   host_wdata,
    output logic                host_gnt,
    output logic                host_rvalid,
    output logic [DATA_W-1:0]   host_rdata,
    output logic                dac_valid,
    output logic [DATA_W-1:0]   dac_data,
    output logic                overrun
);

    ram_req_t ram_req;
    logic     in_window;
    logic     accept;
    logic     host_read;

    assign in_window = (slot_phase(counter) == PH_HOST);
    assign accept    = adc_ready && in_window;
    assign host_read = host_gnt && !host_we;

    ram_port_mux u_mux (
        .active           (!reset),
        .counter          (counter),
        .adc_ready        (adc_ready),
        .fx_address       (fx_address),
        .fx_write_voltage (fx_write_voltage),
        .host_req         (host_req),
        .host_we          (host_we),
        .host_addr        (host_addr),
        .host_wdata       (host_wdata),
        .ram_req          (ram_req),
        .host_gnt         (host_gnt)
    );

    assign ram_addr        = ram_req.addr;
    assign ram_wdata       = ram_req.wdata;
    assign ram_we          = ram_req.we;
    assign fx_read_voltage = ram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter        <= COUNTER_IDLE;
            sample_voltage <= '0;
            dac_data       <= '0;
            dac_valid      <= 1'b0;
            host_rdata     <= '0;
            host_rvalid    <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            if (accept) begin
                counter        <= '0;
                sample_voltage <= adc_data;
            end else if (counter != COUNTER_IDLE) begin
                counter <= counter + 10'd1;
            end
            if (adc_ready && !in_window) begin
                overrun <= 1'b1;
            end
            // Registered on the write slot so the word is held through the DAC slot.
            dac_valid <= (counter == SLOT_WRITE);
            if (counter == SLOT_WRITE) begin
                dac_data <= fx_send_voltage;
            end
            host_rvalid <= host_read;
            if (host_read) begin
                host_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fx_scheduler.sv
// Self-checking bench for fx_scheduler: directed frames with literal
// expectations, then randomized traffic against a frame-age reference model.
module tb_fx_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        adc_ready = 1'b0;
    logic [9:0]  adc_data = '0;
    logic [9:0]  sample_voltage;
    logic [9:0]  counter;
    logic [12:0] fx_address = '0;
    logic [10:0] fx_write_voltage = '0;
    logic [10:0] fx_send_voltage = '0;
    logic [10:0] fx_read_voltage;
    logic [12:0] ram_addr;
    logic [10:0] ram_wdata;
    logic        ram_we;
    logic [10:0] ram_rdata;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [12:0] host_addr = '0;
    logic [10:0] host_wdata = '0;
    logic        host_gnt;
    logic        host_rvalid;
    logic [10:0] host_rdata;
    logic        dac_valid;
    logic [10:0] dac_data;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    fx_scheduler #(.SAMPLE_W(10), .ADDR_W(13), .DATA_W(11)) dut (
        .clk(clk), .reset(reset),
        .adc_ready(adc_ready), .adc_data(adc_data),
        .sample_voltage(sample_voltage), .counter(counter),
        .fx_address(fx_address), .fx_write_voltage(fx_write_voltage),
        .fx_send_voltage(fx_send_voltage), .fx_read_voltage(fx_read_voltage),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .dac_valid(dac_valid), .dac_data(dac_data), .overrun(overrun)
    );

    // Delay RAM the DUT actually drives; combinational read.
    logic [10:0] ram [0:8191];
    assign ram_rdata = ram[ram_addr];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame age since the last accepted sample, plus the
    // memory contents implied by the slot rules.
    int          m_age;
    logic [9:0]  m_sample;
    logic        m_ovr;
    logic [10:0] m_dacd;
    logic        m_dacv;
    logic        m_rv;
    logic [10:0] m_rd;
    logic [10:0] ref_mem [0:8191];
    logic        u_win, u_gnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_age = 1023; m_sample = '0; m_ovr = 1'b0;
            m_dacd = '0; m_dacv = 1'b0; m_rv = 1'b0; m_rd = '0;
        end else begin
            u_win = (m_age >= 7);
            u_gnt = u_win && host_req && !adc_ready;
            m_dacv = (m_age == 5);
            if (m_age == 5) begin
                m_dacd = fx_send_voltage;
                ref_mem[fx_address] = fx_write_voltage;
            end
            m_rv = u_gnt && !host_we;
            if (m_rv) m_rd = ref_mem[host_addr];
            if (u_gnt && host_we) ref_mem[host_addr] = host_wdata;
            if (adc_ready && !u_win) m_ovr = 1'b1;
            if (adc_ready && u_win) begin
                m_sample = adc_data;
                m_age = 0;
            end else begin
                m_age = (m_age + 1 > 1023) ? 1023 : m_age + 1;
            end
        end
    end

    logic c_win, c_gnt, c_we;
    always @(negedge clk) begin
        if (chk_en) begin
            c_win = !reset && (m_age >= 7);
            c_gnt = c_win && host_req && !adc_ready;
            c_we  = (!reset && m_age == 5) || (c_gnt && host_we);
            check("m_counter", counter, 32'(m_age));
            check("m_sample", sample_voltage, m_sample);
            check("m_overrun", overrun, m_ovr);
            check("m_dac_valid", dac_valid, m_dacv);
            check("m_dac_data", dac_data, m_dacd);
            check("m_host_rvalid", host_rvalid, m_rv);
            check("m_host_rdata", host_rdata, m_rd);
            check("m_host_gnt", host_gnt, c_gnt);
            check("m_ram_we", ram_we, c_we);
            check("m_fx_read", fx_read_voltage, ram_rdata);
            if (!reset && m_age <= 5) check("m_ram_addr_fx", ram_addr, fx_address);
            if (!reset && m_age == 5) check("m_ram_wdata_fx", ram_wdata, fx_write_voltage);
            if (c_gnt) check("m_ram_addr_host", ram_addr, host_addr);
            if (c_gnt && host_we) check("m_ram_wdata_host", ram_wdata, host_wdata);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int a = 0; a < 8192; a++) begin
            ram[a] = '0;
            ref_mem[a] = '0;
        end
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        step(2);
        reset = 1'b0;

        // Idle after reset, then first sample.
        @(negedge clk);
        check("idle_counter", counter, 10'h3FF);
        check("idle_strobes", {dac_valid, host_gnt, host_rvalid, ram_we, overrun}, 5'b0);
        adc_ready = 1'b1; adc_data = 10'h2A0;
        fx_address = 13'h0123; fx_write_voltage = 11'h155; fx_send_voltage = 11'h4FF;
        step(1);
        adc_ready = 1'b0;
        @(negedge clk);
        check("accept_counter", counter, 10'd0);
        check("accept_sample", sample_voltage, 10'h2A0);
        step(3);
        host_req = 1'b1; host_we = 1'b1; host_addr = 13'h1FFF; host_wdata = 11'h7AB;
        @(negedge clk);
        check("host_blocked_c3", host_gnt, 1'b0);
        step(2);
        @(negedge clk);
        check("slot5_we", ram_we, 1'b1);
        check("slot5_addr", ram_addr, 13'h0123);
        check("slot5_wdata", ram_wdata, 11'h155);
        step(1);
        @(negedge clk);
        check("slot6_dac_valid", dac_valid, 1'b1);
        check("slot6_dac_data", dac_data, 11'h4FF);
        check("slot6_we", ram_we, 1'b0);
        check("host_blocked_c6", host_gnt, 1'b0);
        step(1);
        @(negedge clk);
        check("host_wr_gnt", host_gnt, 1'b1);
        check("host_wr_addr", ram_addr, 13'h1FFF);
        check("host_wr_we", ram_we, 1'b1);
        step(1);
        host_we = 1'b0;
        @(negedge clk);
        check("host_rd_gnt", host_gnt, 1'b1);
        step(1);
        host_req = 1'b0;
        @(negedge clk);
        check("host_rvalid", host_rvalid, 1'b1);
        check("host_rdata", host_rdata, 11'h7AB);
        check("dac_valid_once", dac_valid, 1'b0);
        step(1);
        @(negedge clk);
        check("host_rvalid_drop", host_rvalid, 1'b0);

        // Overrun: second sample inside the critical slots.
        adc_ready = 1'b1; adc_data = 10'h155;
        step(1);
        adc_ready = 1'b0;
        step(4);
        adc_ready = 1'b1; adc_data = 10'h111;
        step(1);
        adc_ready = 1'b0;
        @(negedge clk);
        check("ovr_flag", overrun, 1'b1);
        check("ovr_sample_kept", sample_voltage, 10'h155);
        check("ovr_counter", counter, 10'd5);
        step(15);
        @(negedge clk);
        check("late_counter", counter, 10'd20);
        adc_ready = 1'b1; adc_data = 10'h0AA;
        step(1);
        adc_ready = 1'b0;
        @(negedge clk);
        check("late_restart", counter, 10'd0);
        check("late_sample", sample_voltage, 10'h0AA);
        check("ovr_sticky", overrun, 1'b1);

        // Sample and host request collide in the window.
        step(9);
        adc_ready = 1'b1; adc_data = 10'h3C3; host_req = 1'b1; host_we = 1'b0;
        @(negedge clk);
        check("collide_counter", counter, 10'd9);
        check("collide_gnt", host_gnt, 1'b0);
        step(1);
        adc_ready = 1'b0; host_req = 1'b0;
        @(negedge clk);
        check("collide_restart", counter, 10'd0);
        check("collide_no_rvalid", host_rvalid, 1'b0);

        // Reset mid-frame.
        step(3);
        reset = 1'b1;
        @(negedge clk);
        check("rst_counter", counter, 10'h3FF);
        step(1);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_no_write_dac", {ram_we, dac_valid}, 2'b00);
            step(1);
        end

        // Long idle with host traffic: counter must saturate.
        adc_ready = 1'b1; adc_data = 10'h001;
        step(1);
        adc_ready = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            host_req   = 1'($urandom_range(0, 1));
            host_we    = 1'($urandom_range(0, 1));
            host_addr  = 13'($urandom_range(0, 15));
            host_wdata = 11'($urandom);
            step(1);
        end
        @(negedge clk);
        check("saturate", counter, 10'h3FF);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            adc_ready        = ($urandom_range(0, 9) == 0);
            adc_data         = 10'($urandom);
            host_req         = 1'($urandom_range(0, 1));
            host_we          = 1'($urandom_range(0, 1));
            host_addr        = 13'($urandom_range(0, 15));
            host_wdata       = 11'($urandom);
            fx_address       = 13'($urandom_range(0, 15));
            fx_write_voltage = 11'($urandom);
            fx_send_voltage  = 11'($urandom);
            reset            = ($urandom_range(0, 399) == 0);
            step(1);
        end
        reset = 1'b0;
        step(2);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
